conv_layer1_ctrl: RTL and testbench
===================================

Name: conv_layer1_ctrl

Overview:
Sequencer for the layer-1 5x5 convolution engine. It streams one input feature map from the fmap buffer into the engine once per output channel, and pulses the engine's rst/self_rst between channels so the engine's internal channel counter selects the next weight set. It also generates write enables and addresses for the layer-1 output buffer from the engine's valid strobe. It sits between the top-level layer scheduler (start/done) and the convolution engine plus its input and output buffers.

Parameters:
I_SIZE, 28, input map side length
K_SIZE, 5, kernel side length
CO, 4, output channels (conv passes per start)
RD_ADDR_BW, 10, fmap read address width (must hold I_SIZE*I_SIZE-1)
WR_ADDR_BW, 12, output write address width (must hold CO*O_SIZE*O_SIZE-1)
O_SIZE, I_SIZE-K_SIZE+1 (24), output map side (localparam)

Ports:
clk  in  1  clock
global_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start a full layer-1 pass; sampled only in IDLE
i_conv_valid  in  1  engine output-valid strobe
i_conv_end  in  1  engine end-of-map level
i_conv_all_end  in  1  engine all-channels-done level
o_fmap_rd  out  1  fmap buffer read enable (buffer has 1-cycle read latency)
o_fmap_addr  out  RD_ADDR_BW  fmap read address
o_conv_ce  out  1  engine clock enable; o_fmap_rd delayed 1 cycle
o_conv_rst  out  1  engine synchronous clear pulse
o_conv_self_rst  out  1  engine channel-advance pulse
o_ch_idx  out  clog2(CO)  current output channel
o_wr_en  out  1  output buffer write enable
o_wr_addr  out  WR_ADDR_BW  output buffer write address
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at end of pass
o_err  out  1  sticky error flag; cleared by i_start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- FSM states: IDLE, CLR, STREAM, DRAIN, NEXT, DONE.
- IDLE: on i_start go to CLR; clear o_err, o_ch_idx and the write counter.
- CLR: hold o_conv_rst=1 for exactly one cycle, then go to STREAM.
- STREAM: hold o_fmap_rd=1 for I_SIZE*I_SIZE consecutive cycles with o_fmap_addr = 0,1,...,783. No gaps are allowed, because the engine shift registers assume a continuous stream. After the last address, go to DRAIN.
- o_conv_ce is a registered copy of o_fmap_rd. The engine therefore sees pixel n one cycle after address n.
- DRAIN: wait for i_conv_end=1, then go to NEXT.
- NEXT: assert o_conv_rst and o_conv_self_rst together for one cycle. If o_ch_idx==CO-1, go to DONE; otherwise increment o_ch_idx and go to STREAM (addresses restart at 0).
- DONE: pulse o_done for one cycle and return to IDLE. If i_conv_all_end==0 in DONE, set o_err.
- Write path: o_wr_en is i_conv_valid registered 1 cycle, and is only generated while o_busy=1. o_wr_addr = o_ch_idx*O_SIZE*O_SIZE + per-channel write count. The per-channel count resets in NEXT.
- Count check: if the per-channel count != O_SIZE*O_SIZE (576) on entry to NEXT, set o_err. A valid arriving when the count is already 576 is dropped (no write) and sets o_err.
- i_start outside IDLE is ignored.
- A global_rst_n assertion mid-pass aborts immediately to IDLE with all outputs 0. There is no resume.

Optional Feature:
CONV_CTRL_WATCHDOG_EN
- Defined: a 16-bit counter runs in DRAIN. If it reaches 16'hFFFF without i_conv_end, set o_err, force NEXT, and continue with the next channel.
- Undefined: DRAIN waits indefinitely; the counter is not instantiated.

Decomposition:
- Shared package/header holds: FSM state encoding, O_SIZE and per-channel pixel/output count localparams, and clog2 (the existing clog2_function.vh).
- One sub-module: conv_ctrl_wr_addr_gen (per-channel write counter, base-address multiply-accumulate by O_SIZE*O_SIZE, overflow/underflow detection feeding o_err).

Test Plan:
- Defaults with engine model; i_start pulse -> 1-cycle o_conv_rst, then 784 contiguous o_fmap_rd with addresses 0..783, and o_conv_ce = o_fmap_rd delayed by exactly 1 cycle.
- Full pass -> 4 o_conv_self_rst pulses, o_ch_idx steps 0..3, 2304 writes with addresses 0..2303 each exactly once, one o_done pulse, o_err=0.
- Model emits only 575 valids in channel 2 -> o_err=1 at NEXT; pass still completes; the next i_start clears o_err.
- i_start held high through a full pass -> a second pass starts only after returning to IDLE; no restart mid-pass.
- global_rst_n dropped mid-STREAM at address 400 -> all outputs 0 asynchronously; a fresh i_start restarts at channel 0, address 0.
- CONV_CTRL_WATCHDOG_EN defined, i_conv_end tied 0 -> after 65535 DRAIN cycles o_err=1 and the next channel begins; undefined -> FSM remains in DRAIN.

Source files
------------

// File: rtl/conv_layer1_ctrl_pkg.sv
// Shared types and helpers for the layer-1 convolution sequencer.
// Optional build macro used by the top: CONV_CTRL_WATCHDOG_EN.
package conv_layer1_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } ctrl_state_t;

  localparam int unsigned DEF_I_SIZE = 28;
  localparam int unsigned DEF_K_SIZE = 5;
  localparam int unsigned DEF_CO     = 4;

  // Never returns 0 so single-entry ranges still get a 1-bit signal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned o_size(input int unsigned i_size, input int unsigned k_size);
    return i_size - k_size + 1;
  endfunction

  function automatic int unsigned pix_per_ch(input int unsigned i_size);
    return i_size * i_size;
  endfunction

  function automatic int unsigned out_per_ch(input int unsigned i_size, input int unsigned k_size);
    return o_size(i_size, k_size) * o_size(i_size, k_size);
  endfunction

endpackage

// File: rtl/conv_ctrl_wr_addr_gen.sv
// Output-buffer write strobe/address generator: per-channel count plus channel base,
// with overflow (extra valid) and short-count detection reported as a one-cycle err pulse.
module conv_ctrl_wr_addr_gen
  import conv_layer1_ctrl_pkg::*;
#(
  parameter int unsigned OUT_PER_CH = 576,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned WR_ADDR_BW = 12
) (
  input  logic                  clk,
  input  logic                  global_rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  valid,
  input  logic                  chk,
  input  logic [CH_W-1:0]       ch_idx,
  output logic                  wr_en,
  output logic [WR_ADDR_BW-1:0] wr_addr,
  output logic                  err
);

  localparam int unsigned CNT_W = clog2(OUT_PER_CH + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(OUT_PER_CH);
  localparam logic [WR_ADDR_BW-1:0] CH_STEP  = WR_ADDR_BW'(OUT_PER_CH);

  logic [CNT_W-1:0]      cnt;
  logic [WR_ADDR_BW-1:0] base;
  logic                  full;

  assign base = WR_ADDR_BW'(ch_idx) * CH_STEP;
  assign full = (cnt == CNT_FULL);

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (en && valid) begin
        if (full) begin
          err <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= base + WR_ADDR_BW'(cnt);
          cnt     <= cnt + 1'b1;
        end
      end
      // chk is sampled against the count before the same-cycle clear
      if (chk && !full) err <= 1'b1;
    end
  end

endmodule

// File: rtl/conv_layer1_ctrl.sv
// Layer-1 5x5 conv sequencer: streams the fmap once per output channel and drives the
// engine clear/advance pulses. Optional macro CONV_CTRL_WATCHDOG_EN adds a DRAIN timeout.
//
// state  | meaning
// IDLE   | waiting for i_start
// CLR    | one-cycle engine clear before the first channel
// STREAM | contiguous fmap read, addresses 0..I_SIZE*I_SIZE-1
// DRAIN  | waiting for the engine end-of-map level
// NEXT   | engine clear + channel advance, count check
// DONE   | o_done pulse, all-channels check
module conv_layer1_ctrl
  import conv_layer1_ctrl_pkg::*;
#(
  parameter int unsigned I_SIZE     = DEF_I_SIZE,
  parameter int unsigned K_SIZE     = DEF_K_SIZE,
  parameter int unsigned CO         = DEF_CO,
  parameter int unsigned RD_ADDR_BW = 10,
  parameter int unsigned WR_ADDR_BW = 12,
  localparam int unsigned CH_W      = clog2(CO)
) (
  input  logic                  clk,
  input  logic                  global_rst_n,
  input  logic                  i_start,
  input  logic                  i_conv_valid,
  input  logic                  i_conv_end,
  input  logic                  i_conv_all_end,
  output logic                  o_fmap_rd,
  output logic [RD_ADDR_BW-1:0] o_fmap_addr,
  output logic                  o_conv_ce,
  output logic                  o_conv_rst,
  output logic                  o_conv_self_rst,
  output logic [CH_W-1:0]       o_ch_idx,
  output logic                  o_wr_en,
  output logic [WR_ADDR_BW-1:0] o_wr_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [RD_ADDR_BW-1:0] LAST_ADDR = RD_ADDR_BW'(pix_per_ch(I_SIZE) - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CO - 1);

  ctrl_state_t state;
  logic        wr_err;

`ifdef CONV_CTRL_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        drain_exit;
  assign drain_exit = i_conv_end || (wd_cnt == 16'hFFFF);
`else
  logic        drain_exit;
  assign drain_exit = i_conv_end;
`endif

  conv_ctrl_wr_addr_gen #(
    .OUT_PER_CH (out_per_ch(I_SIZE, K_SIZE)),
    .CH_W       (CH_W),
    .WR_ADDR_BW (WR_ADDR_BW)
  ) u_wr_addr_gen (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .clr          ((state == S_IDLE) || (state == S_NEXT)),
    .en           (o_busy),
    .valid        (i_conv_valid),
    .chk          (state == S_NEXT),
    .ch_idx       (o_ch_idx),
    .wr_en        (o_wr_en),
    .wr_addr      (o_wr_addr),
    .err          (wr_err)
  );

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state           <= S_IDLE;
      o_fmap_rd       <= 1'b0;
      o_fmap_addr     <= '0;
      o_conv_ce       <= 1'b0;
      o_conv_rst      <= 1'b0;
      o_conv_self_rst <= 1'b0;
      o_ch_idx        <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
`ifdef CONV_CTRL_WATCHDOG_EN
      wd_cnt          <= '0;
`endif
    end else begin
      o_conv_ce <= o_fmap_rd;
      o_done    <= 1'b0;
      if (wr_err) o_err <= 1'b1;
`ifdef CONV_CTRL_WATCHDOG_EN
      wd_cnt <= (state == S_DRAIN) ? wd_cnt + 16'd1 : 16'd0;
      if (state == S_DRAIN && !i_conv_end && wd_cnt == 16'hFFFF) o_err <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_CLR;
            o_busy     <= 1'b1;
            o_conv_rst <= 1'b1;
            o_err      <= 1'b0;
            o_ch_idx   <= '0;
          end
        end
        S_CLR: begin
          o_conv_rst  <= 1'b0;
          o_fmap_rd   <= 1'b1;
          o_fmap_addr <= '0;
          state       <= S_STREAM;
        end
        S_STREAM: begin
          if (o_fmap_addr == LAST_ADDR) begin
            o_fmap_rd   <= 1'b0;
            o_fmap_addr <= '0;
            state       <= S_DRAIN;
          end else begin
            o_fmap_addr <= o_fmap_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            o_conv_rst      <= 1'b1;
            o_conv_self_rst <= 1'b1;
            state           <= S_NEXT;
          end
        end
        S_NEXT: begin
          o_conv_rst      <= 1'b0;
          o_conv_self_rst <= 1'b0;
          if (o_ch_idx == LAST_CH) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            o_ch_idx    <= o_ch_idx + 1'b1;
            o_fmap_rd   <= 1'b1;
            o_fmap_addr <= '0;
            state       <= S_STREAM;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          if (!i_conv_all_end) o_err <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer1_ctrl.sv
// Directed bench for conv_layer1_ctrl with a behavioural 5x5 engine model.
// Build with CONV_CTRL_WATCHDOG_EN defined to exercise the DRAIN timeout path.
module tb_conv_layer1_ctrl;

  localparam int NPIX = 784;
  localparam int NOUT = 2304;

  logic        clk = 1'b0;
  logic        global_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_conv_valid = 1'b0;
  logic        i_conv_end = 1'b0;
  logic        i_conv_all_end = 1'b0;
  logic        o_fmap_rd;
  logic [9:0]  o_fmap_addr;
  logic        o_conv_ce;
  logic        o_conv_rst;
  logic        o_conv_self_rst;
  logic [1:0]  o_ch_idx;
  logic        o_wr_en;
  logic [11:0] o_wr_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  conv_layer1_ctrl dut (
    .clk             (clk),
    .global_rst_n    (global_rst_n),
    .i_start         (i_start),
    .i_conv_valid    (i_conv_valid),
    .i_conv_end      (i_conv_end),
    .i_conv_all_end  (i_conv_all_end),
    .o_fmap_rd       (o_fmap_rd),
    .o_fmap_addr     (o_fmap_addr),
    .o_conv_ce       (o_conv_ce),
    .o_conv_rst      (o_conv_rst),
    .o_conv_self_rst (o_conv_self_rst),
    .o_ch_idx        (o_ch_idx),
    .o_wr_en         (o_wr_en),
    .o_wr_addr       (o_wr_addr),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  // engine model: valid for pixels with row>=4 and col>=4 (576 per channel)
  int drop_ch = -1;
  bit no_end  = 1'b0;
  int pix = 0;
  int selfc = 0;

  always @(negedge clk) begin
    if (!global_rst_n) begin
      pix = 0; selfc = 0;
      i_conv_valid = 1'b0; i_conv_end = 1'b0; i_conv_all_end = 1'b0;
    end else begin
      i_conv_valid = 1'b0;
      if (o_conv_rst) begin
        pix = 0;
        i_conv_end = 1'b0;
        if (o_conv_self_rst) selfc++; else selfc = 0;
      end else if (o_conv_ce) begin
        i_conv_valid = (pix / 28 >= 4) && (pix % 28 >= 4) &&
                       !(drop_ch == int'(o_ch_idx) && pix == NPIX - 1);
        pix++;
        if (pix == NPIX) i_conv_end = !no_end;
      end
      i_conv_all_end = (selfc >= 4);
    end
  end

  // monitor: counters only ever grow; the main flow compares deltas
  int addr_bad = 0, run_bad = 0, ce_bad = 0, ch_bad = 0, oob = 0;
  int runs = 0, run_len = 0, exp_addr = 0, run_in_pass = 0;
  int wr_cnt = 0, self_cnt = 0, rst_cnt = 0, done_cnt = 0, err_rise_self = -1;
  int hit [NOUT];
  bit prev_rd = 1'b0, prev_err = 1'b0;

  initial foreach (hit[i]) hit[i] = 0;

  always @(negedge clk) begin
    if (!global_rst_n) begin
      prev_rd = 1'b0; prev_err = 1'b0; exp_addr = 0; run_len = 0;
    end else begin
      if (o_conv_rst && !o_conv_self_rst) run_in_pass = 0;
      if (o_fmap_rd) begin
        if (!prev_rd && int'(o_ch_idx) != run_in_pass) ch_bad++;
        if (int'(o_fmap_addr) != exp_addr) addr_bad++;
        exp_addr++;
        run_len++;
      end else if (prev_rd) begin
        if (run_len != NPIX) run_bad++;
        runs++;
        run_in_pass++;
        run_len = 0;
        exp_addr = 0;
      end
      if (o_conv_ce != prev_rd) ce_bad++;
      prev_rd = o_fmap_rd;
      if (o_wr_en) begin
        wr_cnt++;
        if (int'(o_wr_addr) < NOUT) hit[o_wr_addr]++; else oob++;
      end
      if (o_conv_self_rst) self_cnt++;
      if (o_conv_rst) rst_cnt++;
      if (o_done) done_cnt++;
      if (o_err && !prev_err) err_rise_self = self_cnt;
      prev_err = o_err;
    end
  end

  int tests = 0, fails = 0;
  int s_runs, s_self, s_rst, s_done, s_wr;
  int hit0 [NOUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_runs = runs; s_self = self_cnt; s_rst = rst_cnt; s_done = done_cnt; s_wr = wr_cnt;
    hit0 = hit;
  endtask

  function automatic int hit_bad();
    int b = 0;
    for (int i = 0; i < NOUT; i++) if (hit[i] - hit0[i] != 1) b++;
    return b;
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (o_done) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_addr_seq"}, addr_bad, 0);
    check({tag, "_run_len"}, run_bad, 0);
    check({tag, "_ce_delay"}, ce_bad, 0);
    check({tag, "_ch_idx"}, ch_bad, 0);
    check({tag, "_wr_oob"}, oob, 0);
  endtask

  initial begin
    tick(3);
    check("rst_ctrl", {o_fmap_rd, o_conv_ce, o_conv_rst, o_conv_self_rst,
                       o_wr_en, o_busy, o_done, o_err}, 0);
    check("rst_fmap_addr", o_fmap_addr, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_ch_idx", o_ch_idx, 0);
    global_rst_n = 1'b1;
    tick(2);

    // full nominal pass
    snap();
    pulse_start();
    check("clr_rst", o_conv_rst, 1);
    check("clr_rd", o_fmap_rd, 0);
    tick(1);
    check("stream0_rst", o_conv_rst, 0);
    check("stream0_rd", o_fmap_rd, 1);
    check("stream0_addr", o_fmap_addr, 0);
    check("stream0_ce", o_conv_ce, 0);
    tick(1);
    check("stream1_ce", o_conv_ce, 1);
    check("stream1_addr", o_fmap_addr, 1);
    wait_done("a_done_seen");
    tick(3);
    check_clean("a");
    check("a_runs", runs - s_runs, 4);
    check("a_self_rst", self_cnt - s_self, 4);
    check("a_conv_rst", rst_cnt - s_rst, 5);
    check("a_done_cnt", done_cnt - s_done, 1);
    check("a_writes", wr_cnt - s_wr, NOUT);
    check("a_addr_once", hit_bad(), 0);
    check("a_err", o_err, 0);
    check("a_busy_end", o_busy, 0);

    // channel 2 short by one valid
    drop_ch = 2;
    snap();
    pulse_start();
    wait_done("b_done_seen");
    tick(3);
    drop_ch = -1;
    check("b_err", o_err, 1);
    check("b_err_at_ch2", err_rise_self - s_self, 3);
    check("b_writes", wr_cnt - s_wr, NOUT - 1);
    check("b_self_rst", self_cnt - s_self, 4);
    check("b_done_cnt", done_cnt - s_done, 1);
    snap();
    pulse_start();
    check("b2_err_cleared", o_err, 0);
    wait_done("b2_done_seen");
    tick(3);
    check("b2_err", o_err, 0);
    check("b2_addr_once", hit_bad(), 0);

    // i_start held high through a pass
    snap();
    i_start = 1'b1;
    wait_done("c_done_seen");
    check("c_no_restart", rst_cnt - s_rst, 5);
    check("c_runs", runs - s_runs, 4);
    tick(2);
    check("c_restart_busy", o_busy, 1);
    check("c_restart_clr", o_conv_rst, 1);
    i_start = 1'b0;
    wait_done("c2_done_seen");
    tick(3);
    check("c_done_cnt", done_cnt - s_done, 2);
    check("c_err", o_err, 0);
    check_clean("c");

    // async reset mid-stream
    pulse_start();
    begin
      bit found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
        @(negedge clk);
        if (o_fmap_rd && o_fmap_addr == 10'd400) found = 1'b1;
      end
      check("d_reach_400", found, 1);
    end
    #2 global_rst_n = 1'b0;
    #1;
    check("d_async_ctrl", {o_fmap_rd, o_conv_ce, o_conv_rst, o_conv_self_rst,
                           o_wr_en, o_busy, o_done, o_err}, 0);
    check("d_async_addr", o_fmap_addr, 0);
    check("d_async_ch", o_ch_idx, 0);
    tick(2);
    global_rst_n = 1'b1;
    tick(2);
    snap();
    pulse_start();
    tick(1);
    check("d_restart_rd", o_fmap_rd, 1);
    check("d_restart_addr", o_fmap_addr, 0);
    check("d_restart_ch", o_ch_idx, 0);
    wait_done("d_done_seen");
    tick(3);
    check("d_writes", wr_cnt - s_wr, NOUT);
    check("d_addr_once", hit_bad(), 0);
    check("d_err", o_err, 0);
    check_clean("d");

    // engine never signals end-of-map
    no_end = 1'b1;
    snap();
    pulse_start();
    begin
      bit drained = 1'b0;
      for (int i = 0; i < 1000 && !drained; i++) begin
        @(negedge clk);
        if (runs - s_runs == 1) drained = 1'b1;
      end
      check("e_first_run", drained, 1);
    end
    tick(300);
    check("e_drain_self_rst", self_cnt - s_self, 0);
    check("e_drain_busy", o_busy, 1);
    check("e_drain_rd", o_fmap_rd, 0);
`ifdef CONV_CTRL_WATCHDOG_EN
    begin
      bit resumed = 1'b0;
      for (int i = 0; i < 66000 && !resumed; i++) begin
        @(negedge clk);
        if (o_fmap_rd) resumed = 1'b1;
      end
      check("e_wd_resumed", resumed, 1);
    end
    check("e_wd_err", o_err, 1);
    check("e_wd_ch", o_ch_idx, 1);
    check("e_wd_self_rst", self_cnt - s_self, 1);
`else
    tick(500);
    check("e_hold_self_rst", self_cnt - s_self, 0);
    check("e_hold_err", o_err, 0);
`endif
    global_rst_n = 1'b0;
    no_end = 1'b0;
    tick(2);
    global_rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
